// File: rtl/rv32m_muldiv_unit.sv
// rv32m_muldiv_unit: RV32M multiply/divide unit with iterative restoring divider.
// Define RV32M_MULDIV_DIV_BYPASS_EN to finish divide-by-zero/overflow in 2 cycles.
module rv32m_muldiv_unit #(
    parameter int MUL_LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic        inst_mul_i,
    input  logic        inst_mulh_i,
    input  logic        inst_mulhsu_i,
    input  logic        inst_mulhu_i,
    input  logic        inst_div_i,
    input  logic        inst_divu_i,
    input  logic        inst_rem_i,
    input  logic        inst_remu_i,
    input  logic [31:0] operand_ra_i,
    input  logic [31:0] operand_rb_i,
    output logic        ready_o,
    output logic        stall_o,
    output logic [31:0] result_o
);
    typedef enum logic [1:0] {IDLE, MUL, DIV_ITER, DIV_FIX} state_e;
    state_e state_q, state_d;
    logic [2:0] op_q, op_d, op_in;
    logic [4:0] cnt_q, cnt_d;
    logic [31:0] ra_q, ra_d, rb_q, rb_d, rem_q, rem_d, quo_q, quo_d, result_q, result_d;
    logic ready_q, ready_d, stall_q, stall_d;
    logic any_inst, accept, in_signed, special_in, is_signed, ra_neg, rb_neg, div0, ovf;
    logic [31:0] ra_abs_in, dvs, mul_res, div_res;
    logic [32:0] a33, b33, r_shift, diff;
    logic [63:0] prod;

    assign any_inst = |{inst_mul_i, inst_mulh_i, inst_mulhsu_i, inst_mulhu_i,
                        inst_div_i, inst_divu_i, inst_rem_i, inst_remu_i};
    assign accept = valid_i & any_inst & ~stall_q;
    assign op_in = inst_mul_i ? 3'd0 : inst_mulh_i ? 3'd1 : inst_mulhsu_i ? 3'd2 :
                   inst_mulhu_i ? 3'd3 : inst_div_i ? 3'd4 : inst_divu_i ? 3'd5 :
                   inst_rem_i ? 3'd6 : 3'd7;
    assign in_signed = (op_in == 3'd4) | (op_in == 3'd6);
    assign ra_abs_in = (in_signed & operand_ra_i[31]) ? -operand_ra_i : operand_ra_i;
`ifdef RV32M_MULDIV_DIV_BYPASS_EN
    assign special_in = (operand_rb_i == 32'h0) |
                        (in_signed & (operand_ra_i == 32'h8000_0000) & (operand_rb_i == 32'hFFFF_FFFF));
`else
    assign special_in = 1'b0;
`endif

    // ops 0..3 are multiplies; MULHU zero-extends ra, MULHSU/MULHU zero-extend rb
    assign a33 = {(op_q != 3'd3) & ra_q[31], ra_q};
    assign b33 = {~op_q[1] & rb_q[31], rb_q};
    assign prod = 64'($signed(a33) * $signed(b33));
    assign mul_res = (op_q[1:0] == 2'd0) ? prod[31:0] : prod[63:32];

    assign is_signed = (op_q == 3'd4) | (op_q == 3'd6);
    assign ra_neg = is_signed & ra_q[31];
    assign rb_neg = is_signed & rb_q[31];
    assign dvs = rb_neg ? -rb_q : rb_q;
    assign div0 = rb_q == 32'h0;
    assign ovf = is_signed & (ra_q == 32'h8000_0000) & (rb_q == 32'hFFFF_FFFF);
    assign r_shift = {rem_q, quo_q[31]};
    assign diff = r_shift - {1'b0, dvs};
    // op_q[1] distinguishes REM/REMU from DIV/DIVU
    assign div_res = div0 ? (op_q[1] ? ra_q : 32'hFFFF_FFFF) :
                     ovf ? (op_q[1] ? 32'h0 : 32'h8000_0000) :
                     op_q[1] ? (ra_neg ? -rem_q : rem_q) :
                     ((ra_neg ^ rb_neg) ? -quo_q : quo_q);

    always_comb begin
        state_d = state_q;
        op_d = op_q;
        cnt_d = cnt_q;
        ra_d = ra_q;
        rb_d = rb_q;
        rem_d = rem_q;
        quo_d = quo_q;
        result_d = result_q;
        ready_d = 1'b0;
        stall_d = stall_q;
        case (state_q)
            IDLE: if (accept) begin
                op_d = op_in;
                ra_d = operand_ra_i;
                rb_d = operand_rb_i;
                cnt_d = 5'd0;
                rem_d = 32'h0;
                quo_d = ra_abs_in;
                stall_d = 1'b1;
                state_d = ~op_in[2] ? MUL : special_in ? DIV_FIX : DIV_ITER;
            end
            MUL: if (cnt_q == 5'(MUL_LATENCY - 2)) begin
                state_d = IDLE;
                result_d = mul_res;
                ready_d = 1'b1;
                stall_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
            DIV_ITER: begin
                rem_d = diff[32] ? r_shift[31:0] : diff[31:0];
                quo_d = {quo_q[30:0], ~diff[32]};
                cnt_d = cnt_q + 5'd1;
                state_d = (cnt_q == 5'd31) ? DIV_FIX : DIV_ITER;
            end
            DIV_FIX: begin
                state_d = IDLE;
                result_d = div_res;
                ready_d = 1'b1;
                stall_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q <= 3'd0;
            cnt_q <= 5'd0;
            ra_q <= 32'h0;
            rb_q <= 32'h0;
            rem_q <= 32'h0;
            quo_q <= 32'h0;
            result_q <= 32'h0;
            ready_q <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            cnt_q <= cnt_d;
            ra_q <= ra_d;
            rb_q <= rb_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            result_q <= result_d;
            ready_q <= ready_d;
            stall_q <= stall_d;
        end
    end

    assign ready_o = ready_q;
    assign stall_o = stall_q;
    assign result_o = result_q;
endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// tb_rv32m_muldiv_unit: randomized and directed checks of rv32m_muldiv_unit against an arithmetic model.
module tb_rv32m_muldiv_unit;
    localparam int LAT = 2;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic valid_i = 1'b0;
    logic [7:0] inst = 8'h0;
    logic [31:0] ra = 32'h0, rb = 32'h0;
    logic ready_o, stall_o;
    logic [31:0] result_o;
    int passed = 0, total = 0;
    logic [31:0] last_exp = 32'h0;

    always #5 clk_i = ~clk_i;

    rv32m_muldiv_unit #(.MUL_LATENCY(LAT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i),
        .inst_mul_i(inst[0]), .inst_mulh_i(inst[1]), .inst_mulhsu_i(inst[2]), .inst_mulhu_i(inst[3]),
        .inst_div_i(inst[4]), .inst_divu_i(inst[5]), .inst_rem_i(inst[6]), .inst_remu_i(inst[7]),
        .operand_ra_i(ra), .operand_rb_i(rb),
        .ready_o(ready_o), .stall_o(stall_o), .result_o(result_o)
    );

    function automatic logic [31:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (op)
            0: begin p = longint'(sa) * longint'(sb); return p[31:0]; end
            1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            2: begin p = longint'(sa) * longint'({32'h0, b}); return p[63:32]; end
            3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            6: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input int op, input logic [31:0] a, input logic [31:0] b);
        if (op < 4) return LAT;
`ifdef RV32M_MULDIV_DIV_BYPASS_EN
        if (b == 32'h0 || ((op == 4 || op == 6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
`endif
        return 34;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_in();
        valid_i = 1'b0;
        inst = 8'h0;
    endtask

    task automatic drive(input int op, input logic [31:0] a, input logic [31:0] b, input logic [7:0] extra);
        valid_i = 1'b1;
        inst = (8'd1 << op) | (extra & (8'hFF << (op + 1)));
        ra = a;
        rb = b;
    endtask

    // offers in the current cycle, then follows the unit until ready_o (bounded)
    task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b, input logic [7:0] extra,
                          input logic [31:0] prev, output int lat, output logic [31:0] res,
                          output int stall_bad, output int hold_bad);
        drive(op, a, b, extra);
        stall_bad = 0;
        hold_bad = 0;
        step();
        idle_in();
        lat = 1;
        while (ready_o !== 1'b1 && lat < 60) begin
            if (stall_o !== 1'b1) stall_bad++;
            if (result_o !== prev) hold_bad++;
            step();
            lat++;
        end
        if (stall_o !== 1'b0) stall_bad++;
        res = result_o;
    endtask

    task automatic test_reset();
        step();
        step();
        total++; if (ready_o !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready_o); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_o); else passed++;
        total++; if (result_o !== 32'h0) $display("FAIL reset_result: got %h want 00000000", result_o); else passed++;
        rst_ni = 1'b1;
    endtask

    task automatic test_mul_timing();
        drive(0, 32'd7, 32'd6, 8'h0);
        total++; if (ready_o !== 1'b0) $display("FAIL mul7x6_ready_a: got %b want 0", ready_o); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL mul7x6_stall_a: got %b want 0", stall_o); else passed++;
        step();
        idle_in();
        total++; if (ready_o !== 1'b0) $display("FAIL mul7x6_ready_a1: got %b want 0", ready_o); else passed++;
        total++; if (stall_o !== 1'b1) $display("FAIL mul7x6_stall_a1: got %b want 1", stall_o); else passed++;
        step();
        total++; if (ready_o !== 1'b1) $display("FAIL mul7x6_ready_a2: got %b want 1", ready_o); else passed++;
        total++; if (result_o !== 32'd42) $display("FAIL mul7x6_result: got %h want %h", result_o, 32'd42); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL mul7x6_stall_a2: got %b want 0", stall_o); else passed++;
        step();
        total++; if (ready_o !== 1'b0) $display("FAIL mul7x6_ready_a3: got %b want 0", ready_o); else passed++;
        last_exp = 32'd42;
    endtask

    task automatic test_directed();
        int ops[9] = '{1, 2, 3, 4, 6, 4, 6, 5, 7};
        logic [31:0] as[9] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                               32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5};
        logic [31:0] bs[9] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] want[9] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'd5};
        int lat, sb, hb;
        logic [31:0] res;
        for (int i = 0; i < 9; i++) begin
            run_op(ops[i], as[i], bs[i], 8'h0, last_exp, lat, res, sb, hb);
            total++; if (res !== want[i]) $display("FAIL directed%0d_result: got %h want %h", i, res, want[i]); else passed++;
            total++; if (lat != exp_lat(ops[i], as[i], bs[i])) $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, exp_lat(ops[i], as[i], bs[i])); else passed++;
            last_exp = want[i];
        end
    endtask

    task automatic test_random();
        int op, kind, lat, sb, hb;
        logic [31:0] a, b, res, want;
        logic [7:0] extra;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 7);
            kind = $urandom_range(0, 5);
            a = $urandom;
            b = $urandom;
            extra = 8'($urandom);
            if (kind == 0) b = 32'h0;
            if (kind == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (kind == 2) begin
                a = $urandom_range(0, 200) - 100;
                b = $urandom_range(1, 9);
                if ($urandom_range(0, 1) == 1) b = -b;
            end
            want = model(op, a, b);
            run_op(op, a, b, extra, last_exp, lat, res, sb, hb);
            total++; if (res !== want) $display("FAIL rand%0d_result op=%0d a=%h b=%h: got %h want %h", i, op, a, b, res, want); else passed++;
            total++; if (lat != exp_lat(op, a, b)) $display("FAIL rand%0d_latency op=%0d: got %0d want %0d", i, op, lat, exp_lat(op, a, b)); else passed++;
            total++; if (sb != 0) $display("FAIL rand%0d_stall: got %0d bad cycles want 0", i, sb); else passed++;
            total++; if (hb != 0) $display("FAIL rand%0d_hold: got %0d unstable cycles want 0", i, hb); else passed++;
            last_exp = want;
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        drive(4, 32'hFFFF_FF9C, 32'd7, 8'h0);
        step();
        idle_in();
        lat = 1;
        while (ready_o !== 1'b1 && lat < 60) begin
            if (lat >= 4 && lat < 20) drive(0, 32'd9, 32'd9, 8'h0); else idle_in();
            step();
            lat++;
        end
        total++; if (lat != 34) $display("FAIL b2b_div_latency: got %0d want 34", lat); else passed++;
        total++; if (result_o !== 32'hFFFF_FFF2) $display("FAIL b2b_div_result: got %h want fffffff2", result_o); else passed++;
        drive(0, 32'd2, 32'd2, 8'h0);
        step();
        idle_in();
        total++; if (ready_o !== 1'b0) $display("FAIL b2b_ready_r1: got %b want 0", ready_o); else passed++;
        total++; if (result_o !== 32'hFFFF_FFF2) $display("FAIL b2b_hold_r1: got %h want fffffff2", result_o); else passed++;
        step();
        total++; if (ready_o !== 1'b1) $display("FAIL b2b_mul_ready: got %b want 1", ready_o); else passed++;
        total++; if (result_o !== 32'd4) $display("FAIL b2b_mul_result: got %h want 00000004", result_o); else passed++;
        step();
        total++; if (ready_o !== 1'b0) $display("FAIL b2b_ready_after: got %b want 0", ready_o); else passed++;
        last_exp = 32'd4;
    endtask

    task automatic test_reset_midop();
        int lat, sb, hb, pulses;
        logic [31:0] res;
        drive(4, 32'd1000, 32'd3, 8'h0);
        step();
        idle_in();
        for (int c = 1; c < 10; c++) step();
        rst_ni = 1'b0;
        #1;
        total++; if (ready_o !== 1'b0) $display("FAIL midrst_ready: got %b want 0", ready_o); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL midrst_stall: got %b want 0", stall_o); else passed++;
        total++; if (result_o !== 32'h0) $display("FAIL midrst_result: got %h want 00000000", result_o); else passed++;
        step();
        step();
        rst_ni = 1'b1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (ready_o !== 1'b0) pulses++;
        end
        total++; if (pulses != 0) $display("FAIL midrst_no_pulse: got %0d pulses want 0", pulses); else passed++;
        run_op(0, 32'd3, 32'd3, 8'h0, 32'h0, lat, res, sb, hb);
        total++; if (res !== 32'd9) $display("FAIL midrst_mul_result: got %h want 00000009", res); else passed++;
        total++; if (lat != LAT) $display("FAIL midrst_mul_latency: got %0d want %0d", lat, LAT); else passed++;
        last_exp = 32'd9;
    endtask

    initial begin
        test_reset();
        test_mul_timing();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
